// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle for mem_bus_ctrl: CPU request/response, ROM/RAM/KB memory ports
// and the display write port. The slave modport is the controller side; the
// master modport is everything around it (CPU, memories, display sink).
interface mem_bus_ctrl_if #(
  parameter int ROM_AW  = 12,
  parameter int RAM_AW  = 6,
  parameter int KB_AW   = 6,
  parameter int DISP_AW = 15
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [2:0]         req_size;

  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;

  logic               rom_en;
  logic [ROM_AW-1:0]  rom_addr;
  logic [31:0]        rom_rdata;

  logic               ram_en;
  logic [3:0]         ram_we;
  logic [RAM_AW-1:0]  ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  logic               kb_en;
  logic [KB_AW-1:0]   kb_addr;
  logic [31:0]        kb_rdata;

  logic               disp_valid;
  logic               disp_ready;
  logic [DISP_AW-1:0] disp_addr;
  logic [31:0]        disp_wdata;
  logic [3:0]         disp_be;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  rom_en, rom_addr, output rom_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, output ram_rdata,
    input  kb_en, kb_addr, output kb_rdata,
    input  disp_valid, disp_addr, disp_wdata, disp_be, output disp_ready
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output rom_en, rom_addr, input rom_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, input ram_rdata,
    output kb_en, kb_addr, input kb_rdata,
    output disp_valid, disp_addr, disp_wdata, disp_be, input disp_ready
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Handshaked CPU memory controller: decodes one request at a time into
// ROM / RAM / keyboard / display regions, drives synchronous memories with a
// fixed read latency, formats sub-word loads and posts display writes through
// a small FIFO.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request (when the display FIFO is not full)
// WAIT   | legal load issued, counting down the memory read latency
// RESP   | resp_valid high for one cycle, then back to IDLE
module mem_bus_ctrl #(
  parameter int ROM_AW     = 12,
  parameter int RAM_AW     = 6,
  parameter int KB_AW      = 6,
  parameter int DISP_AW    = 15,
  parameter int RD_LAT     = 1,
  parameter int WBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_bus_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         PW     = $clog2(WBUF_DEPTH);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_cnt;
  logic [2:0]         r_size;
  logic [1:0]         r_lo;
  logic [1:0]         r_src;
  logic               r_err;
  logic [31:0]        r_rdata;

  logic [PW:0]        r_count;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [DISP_AW-1:0] r_fa [WBUF_DEPTH];
  logic [31:0]        r_fd [WBUF_DEPTH];
  logic [3:0]         r_fb [WBUF_DEPTH];

  logic [3:0]  w_region;
  logic        w_is_rom, w_is_ram, w_is_kb, w_is_disp, w_unmapped;
  logic        w_misal, w_fault;
  logic        w_full, w_ready, w_accept, w_ok, w_load, w_store;
  logic        w_push, w_pop;
  logic [3:0]  w_be;
  logic [31:0] w_lane;
  logic [31:0] w_src_data;
  logic [31:0] w_fmt;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_region   = bus.req_addr[31:28];
  assign w_is_rom   = (w_region == 4'h0);
  assign w_is_ram   = (w_region == 4'h1);
  assign w_is_kb    = (w_region == 4'h2);
  assign w_is_disp  = (w_region == 4'h3);
  assign w_unmapped = (w_region[3:2] != 2'b00);

  // size[1] wins over size[0]; a byte access can never be misaligned
  assign w_misal = bus.req_size[1] ? (bus.req_addr[1:0] != 2'b00)
                                   : (bus.req_size[0] & bus.req_addr[0]);
  assign w_fault = w_misal | w_unmapped
                 | (bus.req_we & (w_is_rom | w_is_kb))
                 | (~bus.req_we & w_is_disp);

  assign w_full   = (r_count == (PW+1)'(WBUF_DEPTH));
  assign w_ready  = (r_state == S_IDLE) && !w_full;
  assign w_accept = bus.req_valid && w_ready;
  assign w_ok     = w_accept && !w_fault;
  assign w_load   = w_ok && !bus.req_we;
  assign w_store  = w_ok && bus.req_we;
  assign w_push   = w_store && w_is_disp;
  assign w_pop    = (r_count != '0) && bus.disp_ready;

  // byte-lane enables and lane-replicated store data, shared by RAM and display
  always_comb begin
    w_be   = 4'b1111;
    w_lane = bus.req_wdata;
    if (bus.req_size[1]) begin
      w_be   = 4'b1111;
      w_lane = bus.req_wdata;
    end else if (bus.req_size[0]) begin
      w_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      w_lane = {2{bus.req_wdata[15:0]}};
    end else begin
      w_be   = 4'b0001 << bus.req_addr[1:0];
      w_lane = {4{bus.req_wdata[7:0]}};
    end
  end

  // pick the lane of the returning memory word and extend it
  always_comb begin
    case (r_src)
      2'd0:    w_src_data = bus.rom_rdata;
      2'd1:    w_src_data = bus.ram_rdata;
      default: w_src_data = bus.kb_rdata;
    endcase
    w_half = r_lo[1] ? w_src_data[31:16] : w_src_data[15:0];
    case (r_lo)
      2'd0:    w_byte = w_src_data[7:0];
      2'd1:    w_byte = w_src_data[15:8];
      2'd2:    w_byte = w_src_data[23:16];
      default: w_byte = w_src_data[31:24];
    endcase
    if (r_size[1])
      w_fmt = w_src_data;
    else if (r_size[0])
      w_fmt = {{16{w_half[15] & ~r_size[2]}}, w_half};
    else
      w_fmt = {{24{w_byte[7] & ~r_size[2]}}, w_byte};
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_err   = (r_state == S_RESP) && r_err;
  assign bus.resp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;

  assign bus.rom_en    = w_load && w_is_rom;
  assign bus.rom_addr  = bus.req_addr[ROM_AW+1:2];
  assign bus.ram_en    = w_ok && w_is_ram;
  assign bus.ram_we    = (w_store && w_is_ram) ? w_be : 4'b0000;
  assign bus.ram_addr  = bus.req_addr[RAM_AW+1:2];
  assign bus.ram_wdata = w_lane;
  assign bus.kb_en     = w_load && w_is_kb;
  assign bus.kb_addr   = bus.req_addr[KB_AW+1:2];

  assign bus.disp_valid = (r_count != '0);
  assign bus.disp_addr  = r_fa[r_rptr];
  assign bus.disp_wdata = r_fd[r_rptr];
  assign bus.disp_be    = r_fb[r_rptr];

  // request sequencing: capture the request on accept, wait out the latency, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_size  <= 3'd0;
      r_lo    <= 2'd0;
      r_src   <= 2'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_size  <= bus.req_size;
            r_lo    <= bus.req_addr[1:0];
            r_src   <= w_region[1:0];
            r_err   <= w_fault;
            r_rdata <= 32'h0;
            r_cnt   <= LAT_M1;
            r_state <= w_load ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_rdata <= w_fmt;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // display FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // display FIFO storage; contents are only meaningful below the occupancy
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wptr] <= bus.req_addr[DISP_AW+1:2];
      r_fd[r_wptr] <= w_lane;
      r_fb[r_wptr] <= w_be;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus randomized traffic
// checked against a byte-level behavioural model of the memory map.
module tb_mem_bus_ctrl;

  localparam int ROM_AW     = 12;
  localparam int RAM_AW     = 6;
  localparam int KB_AW      = 6;
  localparam int DISP_AW    = 15;
  localparam int RD_LAT     = 2;
  localparam int WBUF_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .KB_AW(KB_AW), .DISP_AW(DISP_AW)) bus ();

  mem_bus_ctrl #(
    .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .KB_AW(KB_AW), .DISP_AW(DISP_AW),
    .RD_LAT(RD_LAT), .WBUF_DEPTH(WBUF_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memories seen by the DUT, and the model's own view of RAM
  logic [31:0] rom_mem [1<<ROM_AW];
  logic [31:0] ram_mem [1<<RAM_AW];
  logic [31:0] kb_mem  [1<<KB_AW];
  logic [31:0] ram_ref [1<<RAM_AW];
  logic [31:0] rom_q [RD_LAT];
  logic [31:0] ram_q [RD_LAT];
  logic [31:0] kb_q  [RD_LAT];

  assign bus.rom_rdata = rom_q[RD_LAT-1];
  assign bus.ram_rdata = ram_q[RD_LAT-1];
  assign bus.kb_rdata  = kb_q[RD_LAT-1];

  // synchronous memories with an RD_LAT-deep output pipeline
  always @(posedge clk) begin
    for (int i = RD_LAT-1; i > 0; i--) begin
      rom_q[i] <= rom_q[i-1];
      ram_q[i] <= ram_q[i-1];
      kb_q[i]  <= kb_q[i-1];
    end
    if (bus.rom_en) rom_q[0] <= rom_mem[bus.rom_addr];
    if (bus.kb_en)  kb_q[0]  <= kb_mem[bus.kb_addr];
    if (bus.ram_en) begin
      ram_q[0] <= ram_mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic [DISP_AW-1:0] a;
    logic [31:0]        d;
    logic [3:0]         be;
  } dent_t;
  dent_t exp_q[$];
  int    sink_mode = 1;

  // display sink: drives disp_ready and checks every popped entry in order
  always @(negedge clk) begin
    dent_t e;
    case (sink_mode)
      0:       bus.disp_ready = 1'b0;
      1:       bus.disp_ready = 1'b1;
      default: bus.disp_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (rst_n && bus.disp_valid && bus.disp_ready) begin
      if (exp_q.size() == 0) begin
        check("disp_unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("disp_entry", 64'({bus.disp_addr, bus.disp_wdata, bus.disp_be}),
              64'({e.a, e.d, e.be}));
      end
    end
  end

  // one request through the handshake, checked against the behavioural model
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_err);
    int          n, lat, nb, off, exp_lat;
    int unsigned region, idx;
    logic        err, seen_en;
    logic [63:0] m, v;
    logic [31:0] word, rep, exp_rdata;
    logic [3:0]  be;
    logic [6:0]  exp_en;
    dent_t       e;

    got_rdata = 32'h0;
    got_err   = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    #1;
    n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end

    region = addr >> 28;
    nb     = size[1] ? 4 : (size[0] ? 2 : 1);
    off    = int'(addr % 4);
    idx    = addr >> 2;
    err    = (off % nb != 0) || (region > 3) || (we && (region == 0 || region == 2))
             || (!we && region == 3);
    be     = 4'(((1 << nb) - 1) << off);
    for (int b = 0; b < 4; b++) rep[8*b +: 8] = wdata[8*(b % nb) +: 8];

    exp_rdata = 32'h0;
    if (!err && !we) begin
      if (region == 0)      word = rom_mem[idx % (1<<ROM_AW)];
      else if (region == 1) word = ram_ref[idx % (1<<RAM_AW)];
      else                  word = kb_mem[idx % (1<<KB_AW)];
      m = (64'd1 << (8*nb)) - 64'd1;
      v = (64'(word) >> (8*off)) & m;
      if (!size[2] && nb < 4 && v[8*nb-1]) v = v | ~m;
      exp_rdata = v[31:0];
    end
    exp_lat = (!err && !we) ? RD_LAT + 1 : 1;

    exp_en = {!err && !we && region == 0, !err && region == 1, !err && !we && region == 2,
              (!err && we && region == 1) ? be : 4'b0000};
    check("accept_enables", 64'({bus.rom_en, bus.ram_en, bus.kb_en, bus.ram_we}), 64'(exp_en));
    if (exp_en[6]) check("rom_addr", 64'(bus.rom_addr), 64'(idx % (1<<ROM_AW)));
    if (exp_en[5]) check("ram_addr", 64'(bus.ram_addr), 64'(idx % (1<<RAM_AW)));
    if (exp_en[4]) check("kb_addr",  64'(bus.kb_addr),  64'(idx % (1<<KB_AW)));
    if (exp_en[3:0] != 4'b0000) check("ram_wdata", 64'(bus.ram_wdata), 64'(rep));

    if (!err && we && region == 1)
      for (int b = 0; b < 4; b++)
        if (be[b]) ram_ref[idx % (1<<RAM_AW)][8*b +: 8] = rep[8*b +: 8];
    if (!err && we && region == 3) begin
      e.a  = DISP_AW'(idx % (1<<DISP_AW));
      e.d  = rep;
      e.be = be;
      exp_q.push_back(e);
    end

    @(posedge clk);
    seen_en = 1'b0;
    lat     = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      #1;
      if (bus.rom_en || bus.ram_en || bus.kb_en || bus.ram_we != 4'b0000) seen_en = 1'b1;
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    check("resp_latency", 64'(lat), 64'(exp_lat));
    check("resp_err", 64'(got_err), 64'(err));
    check("resp_rdata", 64'(got_rdata), 64'(exp_rdata));
    check("enables_after_accept", 64'(seen_en), 64'd0);
  endtask

  task automatic drain_fifo();
    int n;
    sink_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    check("fifo_drained", 64'(exp_q.size()), 64'd0);
    check("disp_valid_drained", 64'(bus.disp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a, wd;
    logic        we;
    logic [2:0]  sz;
    int          r, seen;

    for (int i = 0; i < (1<<ROM_AW); i++) rom_mem[i] = $urandom;
    for (int i = 0; i < (1<<RAM_AW); i++) begin
      ram_mem[i] = $urandom;
      ram_ref[i] = ram_mem[i];
    end
    for (int i = 0; i < (1<<KB_AW); i++) kb_mem[i] = $urandom;
    for (int i = 0; i < RD_LAT; i++) begin
      rom_q[i] = 32'h0;
      ram_q[i] = 32'h0;
      kb_q[i]  = 32'h0;
    end
    rom_mem[1] = 32'hBEEF_0000;
    ram_mem[0] = 32'h80FF_1234;
    ram_ref[0] = 32'h80FF_1234;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_size  = 3'd0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_rdata}), 64'd0);
    check("rst_outputs", 64'({bus.disp_valid, bus.rom_en, bus.ram_en, bus.kb_en, bus.ram_we}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // directed loads and stores
    do_req(1'b0, 32'h1000_0003, 3'b000, 32'h0, rd, er);
    check("signed_byte_load", 64'(rd), 64'hFFFF_FF80);
    do_req(1'b0, 32'h0000_0006, 3'b101, 32'h0, rd, er);
    check("unsigned_half_load", 64'(rd), 64'h0000_BEEF);
    do_req(1'b1, 32'h1000_0006, 3'b001, 32'h0000_1234, rd, er);
    do_req(1'b0, 32'h1000_0004, 3'b010, 32'h0, rd, er);
    check("half_store_readback", 64'(rd), 64'(32'h1234_0000 | (ram_mem[1] & 32'h0000_FFFF)));

    // faults
    do_req(1'b0, 32'h1000_0002, 3'b010, 32'h0, rd, er);
    check("fault_misaligned_word", 64'({er, rd}), 64'h1_0000_0000);
    do_req(1'b1, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF, rd, er);
    check("fault_rom_store", 64'({er, rd}), 64'h1_0000_0000);
    do_req(1'b0, 32'h3000_0000, 3'b010, 32'h0, rd, er);
    check("fault_disp_load", 64'({er, rd}), 64'h1_0000_0000);
    do_req(1'b0, 32'h5000_0000, 3'b010, 32'h0, rd, er);
    check("fault_unmapped", 64'({er, rd}), 64'h1_0000_0000);

    // display FIFO backpressure: four fill it, the fifth waits for a drain
    drain_fifo();
    @(negedge clk);
    sink_mode = 0;
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'h3000_0000 + 32'(4*i), 3'b010, 32'hA000_0000 + 32'(i), rd, er);
    @(negedge clk);
    #1;
    check("full_req_ready", 64'(bus.req_ready), 64'd0);
    check("full_disp_valid", 64'(bus.disp_valid), 64'd1);
    sink_mode = 1;
    do_req(1'b1, 32'h3000_0010, 3'b010, 32'hA000_0004, rd, er);
    drain_fifo();

    // randomized traffic
    sink_mode = 2;
    for (int t = 0; t < 400; t++) begin
      r  = $urandom_range(0, 5);
      a  = $urandom;
      a[31:28] = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sz = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_req(we, a, sz, wd, rd, er);
    end
    drain_fifo();

    // reset during WAIT with two display entries pending
    @(negedge clk);
    sink_mode = 0;
    do_req(1'b1, 32'h3000_0100, 3'b010, 32'h1111_1111, rd, er);
    do_req(1'b1, 32'h3000_0104, 3'b000, 32'h0000_0022, rd, er);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h1000_0008;
    bus.req_size  = 3'b010;
    #1;
    check("rst_test_accept", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_disp_valid_drop", 64'(bus.disp_valid), 64'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) rst_n = 1'b1;
      #1;
      if (bus.resp_valid) seen = 1;
      @(negedge clk);
    end
    #1;
    check("rst_no_response", 64'(seen), 64'd0);
    check("rst_release_ready", 64'(bus.req_ready), 64'd1);
    check("rst_release_disp", 64'(bus.disp_valid), 64'd0);
    sink_mode = 1;
    do_req(1'b0, 32'h1000_0000, 3'b010, 32'h0, rd, er);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised, handshaked successor to the combinational CPU memory decoder. It accepts one CPU request at a time over a valid/ready interface and decodes the address into ROM, RAM, keyboard or display regions. It drives synchronous memories with a configurable read latency, formats sub-word loads, and generates byte-lane writes without read-modify-write. Display writes are posted through an internal FIFO with backpressure, and misaligned or illegal accesses are flagged.

## Interface
Parameters:
- ROM_AW, 12: ROM word-address width
- RAM_AW, 6: RAM word-address width
- KB_AW, 6: keyboard register word-address width
- DISP_AW, 15: display word-address width
- RD_LAT, 1: read latency of ROM/RAM/KB in cycles, legal range 1..4
- WBUF_DEPTH, 4: display write FIFO depth, power of 2, at least 2

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- req_size  in  3  bit1 = word; else bit0 = half, 0 = byte; bit2 = unsigned load
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  access fault, qualified by resp_valid
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_AW  ROM word index
- rom_rdata  in  32  ROM data
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  RAM_AW  RAM word index
- ram_wdata  out  32  RAM lane-replicated write data
- ram_rdata  in  32  RAM data
- kb_en  out  1  keyboard read enable
- kb_addr  out  KB_AW  keyboard word index
- kb_rdata  in  32  keyboard data
- disp_valid  out  1  display write pending (FIFO not empty)
- disp_ready  in  1  display sink accepts the entry
- disp_addr  out  DISP_AW  FIFO head word index
- disp_wdata  out  32  FIFO head data
- disp_be  out  4  FIFO head byte enables

## Operation
- Region decode on addr[31:28]: 0 = ROM, 1 = RAM, 2 = KB, 3 = DISP, 4..F = unmapped.
- Word index is addr[AW+1:2]. Higher in-region bits are ignored, so the region aliases.
- Accept: req_valid && req_ready. req_ready = (state == IDLE) && FIFO not full.
- FSM states:
  - IDLE: on accept, a legal load goes to WAIT; any other request goes to RESP.
  - WAIT: counts RD_LAT cycles, captures the formatted data, then goes to RESP.
  - RESP: asserts resp_valid for one cycle, then returns to IDLE.
- Faults: resp_err = 1 and there is no memory/FIFO side effect when any of these hold:
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
  - store to ROM or KB
  - load from DISP
  - unmapped region
- Loads:
  - The region enable (rom_en, ram_en or kb_en) is high only in the accept cycle.
  - The byte or half lane is selected by addr[1:0] and sign- or zero-extended per req_size[2]. Word loads return raw data.
- RAM store: issued in the accept cycle.
  - ram_en = 1.
  - ram_we: byte = 0001 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - ram_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- DISP store: pushes {index, lane data, byte enables} into the FIFO, using the same lane and enable rules as RAM.
- FIFO: pop on disp_valid && disp_ready. Push and pop in the same cycle leave the count unchanged. No push can occur when full, because req_ready is low.
- Stores complete (resp_valid) without waiting for the display to drain.

## Timing
- Reset values: FSM = IDLE, FIFO empty, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, disp_valid = 0, all enables and write enables = 0.
- Accept in cycle T:
  - Legal load: memory data is sampled in cycle T+RD_LAT; resp_valid is high in cycle T+RD_LAT+1.
  - Store or fault: resp_valid is high in cycle T+1.
- Next accept: no earlier than the cycle after resp_valid. Peak rate is one store per 2 cycles.
- Reset asserted mid-operation: the FSM returns to IDLE immediately, the FIFO is flushed, and no response is produced for the in-flight request.
- The disp_* outputs are combinational from the FIFO head. They stay stable while disp_valid && !disp_ready.

## Test plan
- Signed byte load at 0x1000_0003, RAM word 0x80FF_1234, RD_LAT = 2: accept T -> ram_en only in T, ram_addr = 0; resp_valid in T+3 with resp_rdata = 0xFFFF_FF80, resp_err = 0.
- Unsigned half load at 0x0000_0006, ROM word 0xBEEF_0000: resp_rdata = 0x0000_BEEF.
- Half store 0x1234 at 0x1000_0006: ram_we = 1100, ram_wdata = 0x1234_1234, ram_addr = 1; resp_valid at T+1.
- Five word stores to 0x3000_0000.. with disp_ready = 0 and WBUF_DEPTH = 4: four are accepted, then req_ready = 0. Raise disp_ready -> entries drain in order and the fifth is accepted.
- Each of the following gives resp_err = 1, resp_rdata = 0 at T+1, and no enables or FIFO push: word load at 0x1000_0002, store to 0x0000_0000, load from 0x3000_0000, load from 0x5000_0000.
- Assert rst_n = 0 during WAIT with 2 FIFO entries pending: resp_valid is never asserted, disp_valid drops to 0 immediately, and req_ready = 1 after release.
